// File: rtl/uart_rx_oversample_if.sv
// Receive-FIFO read port of uart_rx_oversample: pop strobe plus a view of the queue head and status.
interface uart_rx_oversample_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          RdEn;
  logic [7:0]    RxData;
  logic [3:0]    RxFlags;
  logic          RxIFG;
  logic          RxBusy;
  logic [CW-1:0] RxCount;
  logic          oUCRXERR;

  modport master (output RdEn, input RxData, RxFlags, RxIFG, RxBusy, RxCount, oUCRXERR);
  modport slave  (input RdEn, output RxData, RxFlags, RxIFG, RxBusy, RxCount, oUCRXERR);
endinterface

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: 3-sample majority bit recovery, per-frame mode capture,
// and a small receive FIFO carrying {BRK, PE, FE, OE} with each character.
module uart_rx_oversample #(
  parameter int OVS   = 16,
  parameter int DEPTH = 4
) (
  input  logic       MCLK,
  input  logic       reset,
  input  logic       SAMPLE_EN,
  input  logic       Rx,
  input  logic [1:0] wDLEN,
  input  logic       wUCPEN,
  input  logic       wUCPAR,
  input  logic       wUCMSB,
  input  logic       wUCSPB,
  input  logic       wUCRXEIE,
  uart_rx_oversample_if.slave rbus
);
  // state  | meaning
  // IDLE   | waiting for a low line sample (only while armed)
  // START  | validating the start bit, glitches return to IDLE
  // DATA   | capturing wDLEN+5 data bits
  // PARITY | checking the parity bit
  // STOP2  | first of two stop bits
  // STOP1  | final stop bit; push decided at its mid-bit vote

  localparam int TW = $clog2(OVS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TW-1:0] T_A   = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_B   = TW'(OVS / 2);
  localparam logic [TW-1:0] T_C   = TW'(OVS / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP2,
    S_STOP1
  } state_t;

  state_t        state, state_nxt;
  logic          sync1, rxs;
  logic [TW-1:0] tick;
  logic [2:0]    bit_cnt, last_bit, bidx;
  logic          samp_a, samp_b, maj;
  logic          at_decide, at_end, start_det, load_mode;
  logic [1:0]    dlen_m;
  logic          pen_m, par_m, msb_m, spb_m, rxeie_m;
  logic [7:0]    shreg;
  logic          pe_r, fe_r, zero_r, armed;
  logic          fe_fin, brk_fin, push_req;

  logic [11:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, do_push;
  logic [11:0]   head;

  always_ff @(posedge MCLK) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= Rx;
      rxs   <= sync1;
    end
  end

  assign maj       = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
  assign at_decide = SAMPLE_EN && (tick == T_C);
  assign at_end    = SAMPLE_EN && (tick == T_END);
  assign last_bit  = 3'd4 + {1'b0, dlen_m};
  assign bidx      = msb_m ? (last_bit - bit_cnt) : bit_cnt;

  always_ff @(posedge MCLK) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_det = 1'b0;
    load_mode = 1'b0;
    case (state)
      S_IDLE: begin
        if (SAMPLE_EN && !rxs && armed) begin
          state_nxt = S_START;
          start_det = 1'b1;
        end
      end
      S_START: begin
        if (at_decide && maj) begin
          state_nxt = S_IDLE;
        end else if (at_end) begin
          state_nxt = S_DATA;
          load_mode = 1'b1;
        end
      end
      S_DATA: begin
        if (at_end && (bit_cnt == last_bit)) begin
          if (pen_m)      state_nxt = S_PARITY;
          else if (spb_m) state_nxt = S_STOP2;
          else            state_nxt = S_STOP1;
        end
      end
      S_PARITY: begin
        if (at_end) state_nxt = spb_m ? S_STOP2 : S_STOP1;
      end
      S_STOP2: begin
        if (at_end) state_nxt = S_STOP1;
      end
      S_STOP1: begin
        if (at_decide) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      tick    <= '0;
      bit_cnt <= '0;
      samp_a  <= 1'b1;
      samp_b  <= 1'b1;
      dlen_m  <= '0;
      pen_m   <= 1'b0;
      par_m   <= 1'b0;
      msb_m   <= 1'b0;
      spb_m   <= 1'b0;
      rxeie_m <= 1'b0;
      shreg   <= '0;
      pe_r    <= 1'b0;
      fe_r    <= 1'b0;
      zero_r  <= 1'b0;
      armed   <= 1'b1;
    end else begin
      if (state_nxt == S_IDLE || start_det) tick <= '0;
      else if (SAMPLE_EN)                   tick <= (tick == T_END) ? '0 : tick + 1'b1;

      if (SAMPLE_EN && tick == T_A) samp_a <= rxs;
      if (SAMPLE_EN && tick == T_B) samp_b <= rxs;

      if (state_nxt == S_IDLE || load_mode) bit_cnt <= '0;
      else if (state == S_DATA && at_end)   bit_cnt <= bit_cnt + 1'b1;

      if (load_mode) begin
        dlen_m  <= wDLEN;
        pen_m   <= wUCPEN;
        par_m   <= wUCPAR;
        msb_m   <= wUCMSB;
        spb_m   <= wUCSPB;
        rxeie_m <= wUCRXEIE;
        shreg   <= '0;
        pe_r    <= 1'b0;
        fe_r    <= 1'b0;
        zero_r  <= 1'b1;
      end else if (at_decide) begin
        case (state)
          S_DATA: begin
            shreg[bidx] <= maj;
            zero_r      <= zero_r & ~maj;
          end
          S_PARITY: begin
            pe_r   <= (^shreg) ^ maj ^ ~par_m;
            zero_r <= zero_r & ~maj;
          end
          S_STOP2: begin
            fe_r   <= fe_r | ~maj;
            zero_r <= zero_r & ~maj;
          end
          default: ;
        endcase
      end

      // A frame ending on a low stop bit (break or framing error) must see the
      // line return high before another start bit is accepted.
      if (state == S_STOP1 && at_decide && !maj) armed <= 1'b0;
      else if (state == S_IDLE && rxs)           armed <= 1'b1;
    end
  end

  assign fe_fin   = fe_r | ~maj;
  assign brk_fin  = spb_m ? zero_r : (zero_r & ~maj);
  assign push_req = (state == S_STOP1) && at_decide &&
                    (rxeie_m || !(pe_r || fe_fin || brk_fin));

  assign full    = (count == CW'(DEPTH));
  assign pop     = rbus.RdEn && (count != '0);
  assign do_push = push_req && (!full || pop);

  always_ff @(posedge MCLK) begin
    if (!reset) begin
      if (do_push)       mem[wr_ptr] <= {brk_fin, pe_r, fe_fin, 1'b0, shreg};
      else if (push_req) mem[wr_ptr - 1'b1][8] <= 1'b1;
    end
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head          = mem[rd_ptr];
  assign rbus.RxIFG    = (count != '0);
  assign rbus.RxData   = rbus.RxIFG ? head[7:0] : 8'h00;
  assign rbus.RxFlags  = rbus.RxIFG ? head[11:8] : 4'h0;
  assign rbus.oUCRXERR = rbus.RxIFG && (head[10:8] != 3'b000);
  assign rbus.RxBusy   = (state != S_IDLE);
  assign rbus.RxCount  = count;
endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench for uart_rx_oversample: directed frames plus randomized frames
// compared against a line-level reference model and a queue model of the FIFO.
module tb_uart_rx_oversample;
  localparam int OVS   = 16;
  localparam int DEPTH = 4;

  logic       MCLK = 1'b0;
  logic       reset = 1'b1;
  logic       SAMPLE_EN = 1'b0;
  logic       Rx = 1'b1;
  logic [1:0] wDLEN = 2'd3;
  logic       wUCPEN = 1'b0, wUCPAR = 1'b0, wUCMSB = 1'b0, wUCSPB = 1'b0, wUCRXEIE = 1'b0;

  int          checks = 0;
  int          failures = 0;
  logic [11:0] mq[$];

  uart_rx_oversample_if #(.DEPTH(DEPTH)) rbus ();

  uart_rx_oversample #(.OVS(OVS), .DEPTH(DEPTH)) dut (
    .MCLK     (MCLK),
    .reset    (reset),
    .SAMPLE_EN(SAMPLE_EN),
    .Rx       (Rx),
    .wDLEN    (wDLEN),
    .wUCPEN   (wUCPEN),
    .wUCPAR   (wUCPAR),
    .wUCMSB   (wUCMSB),
    .wUCSPB   (wUCSPB),
    .wUCRXEIE (wUCRXEIE),
    .rbus     (rbus)
  );

  always #5 MCLK = ~MCLK;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag);
    logic [11:0] e;
    e = (mq.size() != 0) ? mq[0] : 12'h000;
    chk({tag, ".ifg"},   32'(rbus.RxIFG),    32'(mq.size() != 0));
    chk({tag, ".cnt"},   32'(rbus.RxCount),  32'(mq.size()));
    chk({tag, ".data"},  32'(rbus.RxData),   32'(e[7:0]));
    chk({tag, ".flags"}, 32'(rbus.RxFlags),  32'(e[11:8]));
    chk({tag, ".err"},   32'(rbus.oUCRXERR), 32'((mq.size() != 0) && (e[10:8] != 3'b000)));
    chk({tag, ".busy"},  32'(rbus.RxBusy),   32'(0));
  endtask

  function automatic void model_push(input logic [11:0] e);
    logic [11:0] t;
    if (mq.size() == DEPTH) begin
      t = mq[mq.size() - 1];
      t[8] = 1'b1;
      mq[mq.size() - 1] = t;
    end else begin
      mq.push_back(e);
    end
  endfunction

  // One oversample tick: line value settles through the synchronizer before the strobe.
  task automatic tick(input logic v, input bit rd);
    Rx = v;
    repeat (2 + $urandom_range(0, 1)) @(negedge MCLK);
    SAMPLE_EN = 1'b1;
    rbus.RdEn = rd;
    @(negedge MCLK);
    SAMPLE_EN = 1'b0;
    rbus.RdEn = 1'b0;
  endtask

  task automatic pop_one(input string tag);
    check_head(tag);
    rbus.RdEn = 1'b1;
    @(negedge MCLK);
    rbus.RdEn = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < DEPTH + 1 && mq.size() != 0; k++) pop_one(tag);
    check_head({tag, ".empty"});
  endtask

  task automatic send_frame(input logic [7:0] val, input int dlen, input bit pen, input bit par,
                            input bit msb, input bit spb, input bit rxeie, input bit bad_par,
                            input int bad_stop, input bit pop_at_stop, input int abort_tick);
    int   n, nstop, sidx, ones, rx_val, t_total;
    logic ln[$];
    logic [7:0] v;
    logic b, p;
    bit   pe, fe, brk, allz, push;
    n = dlen + 5;
    nstop = spb ? 2 : 1;
    v = val & 8'((1 << n) - 1);
    ln.push_back(1'b0);
    for (int i = 0; i < n; i++) ln.push_back(msb ? v[n - 1 - i] : v[i]);
    if (pen) begin
      p = par ? ($countones(v) % 2 == 1) : ($countones(v) % 2 == 0);
      ln.push_back(bad_par ? ~p : p);
    end
    for (int s = 0; s < nstop; s++) ln.push_back((bad_stop == s + 1) ? 1'b0 : 1'b1);

    // Receiver view computed from the line bits alone.
    rx_val = 0;
    ones = 0;
    allz = 1'b1;
    for (int i = 0; i < n; i++) begin
      b = ln[1 + i];
      rx_val = msb ? (rx_val * 2 + int'(b)) : (rx_val + (int'(b) << i));
      ones += int'(b);
      if (b) allz = 1'b0;
    end
    sidx = 1 + n;
    if (pen) begin
      ones += int'(ln[sidx]);
      if (ln[sidx]) allz = 1'b0;
      sidx++;
    end
    pe = pen && ((ones % 2) != (par ? 0 : 1));
    fe = 1'b0;
    for (int s = 0; s < nstop; s++) if (!ln[sidx + s]) fe = 1'b1;
    brk = allz && !ln[sidx];
    push = rxeie || !(pe || fe || brk);

    wDLEN = 2'(dlen);
    wUCPEN = pen;
    wUCPAR = par;
    wUCMSB = msb;
    wUCSPB = spb;
    wUCRXEIE = rxeie;
    t_total = 0;
    for (int bi = 0; bi < ln.size(); bi++) begin
      if (bi == 2) begin
        wDLEN = 2'($urandom);
        wUCPEN = 1'($urandom);
        wUCPAR = 1'($urandom);
        wUCMSB = 1'($urandom);
        wUCSPB = 1'($urandom);
        wUCRXEIE = 1'($urandom);
      end
      for (int t = 0; t < OVS; t++) begin
        if (abort_tick >= 0 && t_total == abort_tick) return;
        tick(ln[bi], pop_at_stop && (bi == ln.size() - 1) && (t == OVS / 2 + 1));
        t_total++;
      end
    end
    if (pop_at_stop && mq.size() != 0) void'(mq.pop_front());
    if (push) model_push({brk, pe, fe, 1'b0, 8'(rx_val)});
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
  endtask

  task automatic frame8n1(input logic [7:0] val, input bit pop_at_stop);
    send_frame(val, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, pop_at_stop, -1);
  endtask

  initial begin
    int dl, bs;
    bit pen, par, msb, spb, eie, bp;
    rbus.RdEn = 1'b0;
    repeat (3) @(negedge MCLK);
    check_head("reset");
    reset = 1'b0;
    @(negedge MCLK);
    pop_one("pop_empty");
    check_head("pop_empty.after");

    frame8n1(8'hA5, 1'b0);
    check_head("8n1_a5");
    chk("8n1_a5.data_const", 32'(rbus.RxData), 32'h0000_00A5);
    pop_one("8n1_a5.pop");

    send_frame(8'h53, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, -1);
    check_head("7e2_badpar_noeie");
    send_frame(8'h53, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, -1);
    check_head("7e2_badpar_eie");
    chk("7e2.flags_const", 32'(rbus.RxFlags), 32'h0000_0004);
    pop_one("7e2.pop");

    for (int t = 0; t < 4; t++) tick(1'b0, 1'b0);
    chk("glitch.busy_during", 32'(rbus.RxBusy), 32'(1));
    for (int t = 0; t < OVS; t++) tick(1'b1, 1'b0);
    check_head("glitch.after");

    wDLEN = 2'd3;
    wUCPEN = 1'b0;
    wUCSPB = 1'b0;
    wUCMSB = 1'b0;
    wUCRXEIE = 1'b1;
    for (int t = 0; t < 20 * OVS; t++) tick(1'b0, 1'b0);
    for (int t = 0; t < 2 * OVS; t++) tick(1'b1, 1'b0);
    model_push(12'hA00);
    check_head("break");
    pop_one("break.pop");

    for (int k = 1; k <= 5; k++) frame8n1(8'(k), 1'b0);
    check_head("overrun.full");
    drain("overrun.drain");

    for (int k = 1; k <= 4; k++) frame8n1(8'(8'h10 + k), 1'b0);
    frame8n1(8'h15, 1'b1);
    check_head("pushpop_full");
    drain("pushpop_full.drain");

    for (int f = 0; f < 16; f++) begin
      dl  = int'($urandom_range(0, 3));
      pen = 1'($urandom);
      par = 1'($urandom);
      msb = 1'($urandom);
      spb = 1'($urandom);
      eie = 1'($urandom);
      bp  = ($urandom_range(0, 3) == 0);
      bs  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, spb ? 2 : 1)) : 0;
      send_frame(8'($urandom), dl, pen, par, msb, spb, eie, bp, bs,
                 ($urandom_range(0, 4) == 0), -1);
      check_head($sformatf("rand%0d", f));
      if ($urandom_range(0, 1) == 1) pop_one($sformatf("rand%0d.pop", f));
    end
    drain("rand.drain");

    frame8n1(8'h77, 1'b0);
    send_frame(8'hC3, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 4 * OVS + 5);
    chk("rst_mid.busy_before", 32'(rbus.RxBusy), 32'(1));
    Rx = 1'b1;
    reset = 1'b1;
    SAMPLE_EN = 1'b1;
    rbus.RdEn = 1'b1;
    @(negedge MCLK);
    reset = 1'b0;
    SAMPLE_EN = 1'b0;
    rbus.RdEn = 1'b0;
    mq.delete();
    check_head("rst_mid");
    for (int t = 0; t < 2 * OVS; t++) tick(1'b1, 1'b0);
    check_head("rst_mid.idle");
    frame8n1(8'h3C, 1'b0);
    check_head("rst_mid.3c");
    drain("rst_mid.drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
